// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between the instruction-fetch
//   port and the data port of a processor core. One transaction is served at
//   a time. Data accesses win arbitration, but a starvation counter forces a
//   fetch grant after STARVE_LIMIT consecutive data grants made while a fetch
//   was pending. Each completed transaction produces a one-cycle Done pulse on
//   the owning port. All outputs are registered.
//
// Ports
//   Clock, Resetn            clock (rising edge), asynchronous active-low reset
//   InstrReq/InstrAddr       fetch request and address (held until InstrDone)
//   InstrIn/InstrDone        fetched word and its one-cycle completion pulse
//   ReadData/WriteData       data load/store request (held until DataDone)
//   DataAddr/DataOut         data address and store data from the core
//   DataIn/DataDone          load result and its one-cycle completion pulse
//   MemEn/MemWe              memory strobe (one cycle per access) and write enable
//   MemAddr/MemWrData        memory address and write data (held until next grant)
//   MemRdData                read data, valid MEM_LATENCY cycles after MemEn
//   ProtErr                  sticky flag: load and store requested together
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int ADDR_BITS    = 16,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 InstrReq,
    input  logic [ADDR_BITS-1:0] InstrAddr,
    output logic [WORD_SIZE-1:0] InstrIn,
    output logic                 InstrDone,
    input  logic                 ReadData,
    input  logic                 WriteData,
    input  logic [ADDR_BITS-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    output logic                 MemEn,
    output logic                 MemWe,
    output logic [ADDR_BITS-1:0] MemAddr,
    output logic [WORD_SIZE-1:0] MemWrData,
    input  logic [WORD_SIZE-1:0] MemRdData,
    output logic                 ProtErr
);

    localparam int WCW = $clog2(MEM_LATENCY + 1);
    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCW-1:0] LAT  = WCW'(MEM_LATENCY);
    localparam logic [SCW-1:0] SLIM = SCW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   owner_data_q, owner_data_d;   // 1: data port owns the access
    logic                   is_wr_q, is_wr_d;
    logic [WCW-1:0]         wait_q, wait_d;
    logic [SCW-1:0]         starve_q, starve_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
    logic [WORD_SIZE-1:0]   instr_in_q, instr_in_d;
    logic [WORD_SIZE-1:0]   data_in_q, data_in_d;
    logic                   instr_done_q, instr_done_d;
    logic                   data_done_q, data_done_d;
    logic                   prot_err_q, prot_err_d;

    logic                   data_req;
    logic                   fetch_win;

    assign data_req  = ReadData | WriteData;
    // Fetch wins when it is alone, or when data has already taken its quota
    // of consecutive grants while the fetch waited.
    assign fetch_win = InstrReq & (~data_req | (starve_q == SLIM));

    always_comb begin
        state_d      = state_q;
        owner_data_d = owner_data_q;
        is_wr_d      = is_wr_q;
        wait_d       = wait_q;
        starve_d     = starve_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        instr_in_d   = instr_in_q;
        data_in_d    = data_in_q;
        instr_done_d = 1'b0;
        data_done_d  = 1'b0;
        prot_err_d   = prot_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (ReadData && WriteData) begin
                    prot_err_d = 1'b1;
                end
                if (fetch_win) begin
                    owner_data_d = 1'b0;
                    is_wr_d      = 1'b0;
                    mem_addr_d   = InstrAddr;
                    mem_en_d     = 1'b1;
                    starve_d     = '0;
                    state_d      = S_ISSUE;
                end else if (data_req) begin
                    // A simultaneous load+store is executed as a store.
                    owner_data_d = 1'b1;
                    is_wr_d      = WriteData;
                    mem_addr_d   = DataAddr;
                    mem_en_d     = 1'b1;
                    mem_we_d     = WriteData;
                    if (WriteData) begin
                        mem_wdata_d = DataOut;
                    end
                    if (!InstrReq) begin
                        starve_d = '0;
                    end else if (starve_q != SLIM) begin
                        starve_d = starve_q + 1'b1;
                    end
                    state_d = S_ISSUE;
                end else begin
                    starve_d = '0;
                end
            end
            S_ISSUE: begin
                if (is_wr_q) begin
                    data_done_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wait_d  = WCW'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == LAT) begin
                    if (owner_data_q) begin
                        data_in_d   = MemRdData;
                        data_done_d = 1'b1;
                    end else begin
                        instr_in_d   = MemRdData;
                        instr_done_d = 1'b1;
                    end
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= S_IDLE;
            owner_data_q <= 1'b0;
            is_wr_q      <= 1'b0;
            wait_q       <= '0;
            starve_q     <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            instr_in_q   <= '0;
            data_in_q    <= '0;
            instr_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            prot_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            is_wr_q      <= is_wr_d;
            wait_q       <= wait_d;
            starve_q     <= starve_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            instr_in_q   <= instr_in_d;
            data_in_q    <= data_in_d;
            instr_done_q <= instr_done_d;
            data_done_q  <= data_done_d;
            prot_err_q   <= prot_err_d;
        end
    end

    assign InstrIn   = instr_in_q;
    assign InstrDone = instr_done_q;
    assign DataIn    = data_in_q;
    assign DataDone  = data_done_q;
    assign MemEn     = mem_en_q;
    assign MemWe     = mem_we_q;
    assign MemAddr   = mem_addr_q;
    assign MemWrData = mem_wdata_q;
    assign ProtErr   = prot_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter. Two requester agents (fetch and data) drive
//   the core-side handshakes; a memory model answers MemEn with a fixed-latency
//   pipeline. Agents push expected responses into per-port queues when they
//   issue a request; a negedge monitor checks each grant against a
//   transaction-level arbitration model and pops/compares on every Done pulse.
module tb_mem_port_arbiter;

    localparam int L  = 2;
    localparam int SL = 4;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b1;
    logic        InstrReq = 1'b0;
    logic [15:0] InstrAddr = '0;
    logic [15:0] InstrIn;
    logic        InstrDone;
    logic        ReadData = 1'b0;
    logic        WriteData = 1'b0;
    logic [15:0] DataAddr = '0;
    logic [15:0] DataOut = '0;
    logic [15:0] DataIn;
    logic        DataDone;
    logic        MemEn;
    logic        MemWe;
    logic [15:0] MemAddr;
    logic [15:0] MemWrData;
    logic [15:0] MemRdData;
    logic        ProtErr;

    mem_port_arbiter #(
        .WORD_SIZE(16), .ADDR_BITS(16), .MEM_LATENCY(L), .STARVE_LIMIT(SL)
    ) dut (
        .Clock(Clock), .Resetn(Resetn),
        .InstrReq(InstrReq), .InstrAddr(InstrAddr), .InstrIn(InstrIn), .InstrDone(InstrDone),
        .ReadData(ReadData), .WriteData(WriteData), .DataAddr(DataAddr), .DataOut(DataOut),
        .DataIn(DataIn), .DataDone(DataDone),
        .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWrData(MemWrData),
        .MemRdData(MemRdData), .ProtErr(ProtErr)
    );

    always #5 Clock = ~Clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct { bit is_data; int cyc; } due_t;
    typedef struct { bit is_wr; logic [15:0] val; } dexp_t;

    due_t        due_q[$];
    logic [15:0] fetch_exp_q[$];
    dexp_t       data_exp_q[$];
    bit          grant_log[$];          // 1: data grant, 0: fetch grant
    logic [15:0] ref_mem[int];          // reference view of data-region contents
    logic [15:0] mem_arr[int];          // storage of the memory model
    logic [15:0] pipe[L];

    // Arbitration model state
    int          busy_until = -1;
    int          starve = 0;
    bit          pend = 1'b0;
    bit          p_data, p_we;
    logic [15:0] p_addr, p_wdata;
    bit          prot_exp = 1'b0;
    logic [15:0] last_rd = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    // Initial memory contents; address 5 holds the word the single-fetch case expects.
    function automatic logic [15:0] mem_init(input logic [15:0] a);
        return (a == 16'h0005) ? 16'h4A21 : (a * 16'd37 + 16'h01F3);
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : mem_init(a);
    endfunction

    initial forever begin
        @(posedge Clock);
        cyc++;
    end

    // Memory model: samples the strobe mid-cycle, responds L cycles after MemEn.
    assign MemRdData = pipe[L-1];
    initial begin
        logic        en_s, we_s;
        logic [15:0] a_s, wd_s, rd_now;
        for (int i = 0; i < L; i++) pipe[i] = 16'hDEAD;
        forever begin
            @(negedge Clock);
            en_s = MemEn; we_s = MemWe; a_s = MemAddr; wd_s = MemWrData;
            @(posedge Clock);
            if (en_s && we_s) mem_arr[int'(a_s)] = wd_s;
            rd_now = 16'hDEAD;
            if (en_s && !we_s)
                rd_now = mem_arr.exists(int'(a_s)) ? mem_arr[int'(a_s)] : mem_init(a_s);
            for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= rd_now;
        end
    end

    // Monitor / scoreboard
    initial begin
        due_t        e;
        dexp_t       d;
        logic [15:0] fv;
        bit          dreq;
        forever begin
            @(negedge Clock);
            if (!Resetn) begin
                due_q.delete(); fetch_exp_q.delete(); data_exp_q.delete();
                pend = 1'b0; busy_until = -1; starve = 0;
                prot_exp = 1'b0; last_rd = '0;
            end else begin
                // Memory access granted in the previous idle cycle
                if (pend) begin
                    chk("MemEn_on_grant", MemEn, 1);
                    chk("MemAddr", MemAddr, p_addr);
                    chk("MemWe", MemWe, p_we);
                    if (p_we) chk("MemWrData", MemWrData, p_wdata);
                    grant_log.push_back(p_data);
                    due_q.push_back('{p_data, cyc + (p_we ? 1 : L + 1)});
                    pend = 1'b0;
                end else begin
                    chk("MemEn_no_grant", MemEn, 0);
                end
                // Completion pulses
                if (InstrDone || DataDone) begin
                    chk("both_done", InstrDone & DataDone, 0);
                    if (due_q.size() == 0) begin
                        chk("unexpected_done", {InstrDone, DataDone}, 0);
                    end else begin
                        e = due_q.pop_front();
                        chk("done_port_is_data", DataDone, e.is_data);
                        chk("done_cycle", cyc, e.cyc);
                    end
                    if (InstrDone && fetch_exp_q.size() != 0) begin
                        fv = fetch_exp_q.pop_front();
                        chk("InstrIn", InstrIn, fv);
                    end
                    if (DataDone && data_exp_q.size() != 0) begin
                        d = data_exp_q.pop_front();
                        if (d.is_wr) begin
                            chk("DataIn_kept_on_write", DataIn, last_rd);
                        end else begin
                            chk("DataIn", DataIn, d.val);
                            last_rd = d.val;
                        end
                    end
                    chk("ProtErr_at_done", ProtErr, prot_exp);
                end else if (due_q.size() != 0 && due_q[0].cyc < cyc) begin
                    chk("done_missing_due_cycle", cyc, due_q[0].cyc);
                    e = due_q.pop_front();
                    if (e.is_data && data_exp_q.size() != 0) d = data_exp_q.pop_front();
                    if (!e.is_data && fetch_exp_q.size() != 0) fv = fetch_exp_q.pop_front();
                end
                // Arbitration in an idle cycle
                if (cyc > busy_until) begin
                    dreq = ReadData | WriteData;
                    if (ReadData && WriteData) prot_exp = 1'b1;
                    if (InstrReq && (!dreq || starve == SL)) begin
                        pend = 1'b1; p_data = 1'b0; p_we = 1'b0; p_addr = InstrAddr;
                        starve = 0;
                    end else if (dreq) begin
                        pend = 1'b1; p_data = 1'b1; p_we = WriteData;
                        p_addr = DataAddr; p_wdata = DataOut;
                        starve = InstrReq ? ((starve < SL) ? starve + 1 : SL) : 0;
                    end else begin
                        starve = 0;
                    end
                    if (pend) busy_until = cyc + 1 + (p_we ? 1 : L + 1);
                end
            end
        end
    end

    task automatic wait_done(input bit is_data);
        int  n;
        bit  got;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
            got = is_data ? DataDone : InstrDone;
        end while (!got && n < 200);
        chk(is_data ? "data_done_within_bound" : "fetch_done_within_bound", got, 1);
        @(posedge Clock); #1;
    endtask

    task automatic fetch_txn(input logic [15:0] a);
        fetch_exp_q.push_back(mem_init(a));
        InstrReq = 1'b1; InstrAddr = a;
        wait_done(1'b0);
        InstrReq = 1'b0;
    endtask

    // kind: 0 load, 1 store, 2 load+store together
    task automatic data_txn(input int kind, input logic [15:0] a, input logic [15:0] wd);
        if (kind != 0) begin
            ref_mem[int'(a)] = wd;
            data_exp_q.push_back('{1'b1, 16'h0});
        end else begin
            data_exp_q.push_back('{1'b0, ref_read(a)});
        end
        ReadData = (kind != 1); WriteData = (kind != 0);
        DataAddr = a; DataOut = wd;
        wait_done(1'b1);
        ReadData = 1'b0; WriteData = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge Clock); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int g;
        // Reset state
        #2 Resetn = 1'b0;
        #1;
        chk("reset_ctrl_outputs", {MemEn, MemWe, InstrDone, DataDone, ProtErr}, 0);
        chk("reset_MemAddr", MemAddr, 0);
        cycles(3);
        Resetn = 1'b1;
        cycles(2);

        // Reset in the middle of a fetch's WAIT phase
        InstrReq = 1'b1; InstrAddr = 16'h0010;
        cycles(2);
        InstrReq = 1'b0;
        #2 Resetn = 1'b0;
        #1;
        chk("async_reset_ctrl", {MemEn, MemWe, InstrDone, DataDone, ProtErr}, 0);
        chk("async_reset_MemAddr", MemAddr, 0);
        chk("async_reset_InstrIn", InstrIn, 0);
        chk("async_reset_DataIn", DataIn, 0);
        @(posedge Clock); #1;
        cycles(2);
        Resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            chk("post_reset_InstrDone", InstrDone, 0);
            chk("post_reset_MemEn", MemEn, 0);
        end
        @(posedge Clock); #1;

        // Single fetch
        fetch_txn(16'h0005);
        cycles(1);

        // Store then load
        data_txn(1, 16'h0100, 16'hBEEF);
        data_txn(0, 16'h0100, 16'h0000);
        cycles(2);

        // Simultaneous fetch and load: data first, then fetch
        s = grant_log.size();
        fork
            fetch_txn(16'h0030);
            data_txn(0, 16'h0100, 16'h0000);
        join
        chk("simul_first_grant_data", grant_log[s], 1);
        chk("simul_second_grant_fetch", grant_log[s+1], 0);
        cycles(2);

        // Starvation: fetch held while data streams back-to-back
        s = grant_log.size();
        fork
            fetch_txn(16'h0020);
            for (int k = 0; k < 6; k++) data_txn(k % 2, 16'h0101 + 16'(k), 16'h1000 + 16'(k));
        join
        chk("starve_4th_grant_data", grant_log[s+3], 1);
        chk("starve_5th_grant_fetch", grant_log[s+4], 0);
        chk("starve_6th_grant_data", grant_log[s+5], 1);
        cycles(2);

        // Randomized traffic on both ports
        fork
            for (int i = 0; i < 40; i++) begin
                cycles($urandom_range(0, 3));
                fetch_txn(16'($urandom_range(0, 255)));
            end
            for (int j = 0; j < 60; j++) begin
                g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                cycles(g);
                data_txn($urandom_range(0, 1), 16'h0100 + 16'($urandom_range(0, 15)),
                         16'($urandom));
            end
        join
        cycles(3);

        // Protocol error: load and store together
        chk("proterr_clear_before", ProtErr, 0);
        data_txn(2, 16'h0105, 16'h1357);
        chk("proterr_set", ProtErr, 1);
        data_txn(0, 16'h0105, 16'h0000);
        fetch_txn(16'h0044);
        chk("proterr_sticky", ProtErr, 1);
        #2 Resetn = 1'b0;
        #1;
        chk("proterr_cleared_by_reset", ProtErr, 0);
        cycles(2);
        Resetn = 1'b1;
        cycles(2);
        chk("scoreboard_drained", due_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
